// File: rtl/sad_accum.sv
// Sum-of-absolute-differences accumulator feeding the SAD result register.
// Sequences one block of N_PIX pixel pairs: IDLE -> ACC -> WRITE -> IDLE.
module sad_accum #(
    parameter int PIX_W = 8,
    parameter int N_PIX = 256,
    parameter int SUM_W = 32,
    parameter int IDX_W = $clog2(N_PIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b,
    output logic [IDX_W-1:0] idx,
    output logic [SUM_W-1:0] sum,
    output logic             sad_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic last_beat;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [SUM_W-1:0] zext(input logic [PIX_W-1:0] d);
        return {{(SUM_W-PIX_W){1'b0}}, d};
    endfunction

    assign accept    = pix_valid && (state == ACC);
    assign last_beat = (idx == IDX_W'(N_PIX - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = ACC;
            ACC:     if (accept && last_beat) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sum   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            // Starting a block clears the previous result on the same edge.
            if (state == IDLE && go) begin
                sum <= '0;
                idx <= '0;
            end else if (accept) begin
                sum <= sum + zext(abs_diff(pix_a, pix_b));
                idx <= last_beat ? '0 : idx + 1'b1;
            end
        end
    end

    // All status outputs are pure state decodes.
    assign pix_ready = (state == ACC);
    assign busy      = (state != IDLE);
    assign sad_en    = (state == WRITE);
    assign done      = (state == WRITE);

endmodule
